// File: rtl/pipe_field.sv
// Scrolling pipe field for a flappy-style game: a 16x16 bitmap that shifts left
// (towards higher column indices) once per step, injecting two-column pipes with
// a three-row gap chosen by an 8-bit LFSR, followed by four empty columns.
// Optional feature macro: PIPE_FIELD_DIFFICULTY_EN shortens the step period as
// pipes accumulate (full, half, then quarter period after pipes 8 and 16).
module pipe_field #(
  parameter int unsigned STEP_CYCLES = 1000000,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              gameover,
  output logic [15:0][15:0] rA,
  output logic              step,
  output logic              running,
  output logic [7:0]        pipe_cnt
);

  localparam int unsigned CntW = $clog2(STEP_CYCLES);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     div_q, div_d;
  logic [2:0]          phase_q, phase_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [3:0]          gap_q, gap_d;
  logic [15:0][15:0]   field_q, field_d;
  logic                step_q, step_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [CntW-1:0]     period_m1;
  logic                wrap;
  logic [3:0]          gap_now;
  logic [3:0]          gap_sel;
  logic [15:0]         newcol;

`ifdef PIPE_FIELD_DIFFICULTY_EN
  logic [1:0]          shamt;

  // Period divisor from the pipe count, capped at a shift of two.
  always_comb begin
    shamt = (cnt_q[7:4] != 4'd0) ? 2'd2 : {1'b0, cnt_q[3]};
    period_m1 = CntW'((STEP_CYCLES >> shamt) - 1);
  end
`else
  // Fixed step period.
  always_comb begin
    period_m1 = CntW'(STEP_CYCLES - 1);
  end
`endif

  // Column to inject on the next step; phase 0 uses the fresh gap, phase 1 the latched one.
  always_comb begin
    wrap    = (div_q == period_m1);
    gap_now = {1'b0, lfsr_q[2:0]} + 4'd2;
    gap_sel = (phase_q == 3'd0) ? gap_now : gap_q;
    newcol  = '0;
    if (phase_q <= 3'd1) begin
      for (int r = 0; r < 15; r++) begin
        newcol[r] = !((4'(r) == gap_sel) || (4'(r) == gap_sel + 4'd1) ||
                      (4'(r) == gap_sel + 4'd2));
      end
    end
  end

  // Game FSM plus divider, scroll, LFSR and pipe counter next-state.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    lfsr_d  = lfsr_q;
    gap_d   = gap_q;
    field_d = field_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start && (state_q == StIdle || !gameover)) begin
          state_d = StRun;
          div_d   = '0;
          phase_d = 3'd0;
          lfsr_d  = LFSR_SEED;
          gap_d   = 4'd0;
          field_d = '0;
          cnt_d   = 8'd0;
        end
      end
      StRun: begin
        // gameover wins over a due step: freeze everything.
        if (gameover) begin
          state_d = StHalt;
        end else if (wrap) begin
          div_d  = '0;
          step_d = 1'b1;
          for (int r = 0; r < 16; r++) begin
            field_d[r] = {field_q[r][14:0], newcol[r]};
          end
          phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
          if (phase_q == 3'd0) begin
            gap_d  = gap_now;
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end
        end else begin
          div_d = div_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      phase_q <= 3'd0;
      lfsr_q  <= LFSR_SEED;
      gap_q   <= 4'd0;
      field_q <= '0;
      step_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      lfsr_q  <= lfsr_d;
      gap_q   <= gap_d;
      field_q <= field_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rA       = field_q;
  assign step     = step_q;
  assign running  = (state_q == StRun);
  assign pipe_cnt = cnt_q;

endmodule
